// File: rtl/spram_arb_pkg.sv
// Shared definitions for the two-port SPRAM arbiter: owner encoding,
// read-tracking pipeline stage record and default widths.
package spram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 16;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  // One slot of the outstanding-access pipeline.
  typedef struct packed {
    logic valid;
    logic owner;
    logic is_read;
  } stage_t;

endpackage

// File: rtl/spram_arb_pick.sv
// Grant policy for the two-port SPRAM arbiter.
// SPRAM_ARB_ROUND_ROBIN_EN defined: contention alternates on last owner.
// Undefined: m0 has priority, limited to MAX_CONSECUTIVE wins while m1 waits.
module spram_arb_pick
  import spram_arb_pkg::*;
#(
  parameter int MAX_CONSECUTIVE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_gnt,
  output logic m1_gnt
);

  logic m1_wins;

`ifdef SPRAM_ARB_ROUND_ROBIN_EN
  logic last_owner;

  // Under contention the master that did not own the last transfer wins.
  always_comb begin
    m1_wins = (last_owner == OWNER_M0);
  end

  // Track the owner of every transfer; m1 at reset so m0 goes first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= OWNER_M1;
    end else if (m0_gnt) begin
      last_owner <= OWNER_M0;
    end else if (m1_gnt) begin
      last_owner <= OWNER_M1;
    end
  end
`else
  logic [3:0] streak;

  // m1 takes the slot once m0 has used up its consecutive allowance.
  always_comb begin
    m1_wins = (streak == 4'(MAX_CONSECUTIVE));
  end

  // Count m0 wins while m1 waits; any m1 win or m1 idling restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak <= 4'd0;
    end else if (!m1_req || m1_gnt) begin
      streak <= 4'd0;
    end else if (m0_gnt && (streak != 4'(MAX_CONSECUTIVE))) begin
      streak <= streak + 4'd1;
    end
  end
`endif

  // At most one grant; nothing is granted while reset is held.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset_n) begin
      if (m0_req && m1_req) begin
        m0_gnt = !m1_wins;
        m1_gnt = m1_wins;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

endmodule

// File: rtl/spram_arbiter_2port.sv
// Two-master arbiter in front of a single-port SPRAM with 1-cycle read.
// Registers the RAM command and tracks reads through two stages so each
// master gets its own rvalid. Policy selected by SPRAM_ARB_ROUND_ROBIN_EN.
module spram_arbiter_2port
  import spram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_CONSECUTIVE = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic [1:0]            m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic [1:0]            m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [1:0]            ram_write_en,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  stage_t stage1;
  stage_t stage2;

  spram_arb_pick #(
    .MAX_CONSECUTIVE(MAX_CONSECUTIVE)
  ) u_pick (
    .clk    (clk),
    .reset_n(reset_n),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .m0_gnt (m0_gnt),
    .m1_gnt (m1_gnt)
  );

  // Load the winner's command; idle cycles keep address/data to avoid toggling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr     <= '0;
      ram_din      <= '0;
      ram_write_en <= 2'b00;
      stage1       <= '0;
      stage2       <= '0;
    end else begin
      stage2 <= stage1;
      if (m1_gnt) begin
        ram_addr       <= m1_addr;
        ram_din        <= m1_wdata;
        ram_write_en   <= m1_we;
        stage1.valid   <= 1'b1;
        stage1.owner   <= OWNER_M1;
        stage1.is_read <= (m1_we == 2'b00);
      end else if (m0_gnt) begin
        ram_addr       <= m0_addr;
        ram_din        <= m0_wdata;
        ram_write_en   <= m0_we;
        stage1.valid   <= 1'b1;
        stage1.owner   <= OWNER_M0;
        stage1.is_read <= (m0_we == 2'b00);
      end else begin
        ram_write_en <= 2'b00;
        stage1       <= '0;
      end
    end
  end

  // Read data arrives from the RAM while the access sits in stage 2.
  always_comb begin
    m0_rvalid = stage2.valid && stage2.is_read && (stage2.owner == OWNER_M0);
    m1_rvalid = stage2.valid && stage2.is_read && (stage2.owner == OWNER_M1);
    rdata     = ram_dout;
  end

endmodule

// File: tb/tb_spram_arbiter_2port.sv
// Bench for spram_arbiter_2port: directed scenarios followed by random
// traffic, checked against a transaction-level model of the arbiter and RAM.
module tb_spram_arbiter_2port;

  localparam int AW   = 14;
  localparam int DW   = 16;
  localparam int MAXC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [1:0]    m0_we = 2'b00, m1_we = 2'b00;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] rdata, ram_din;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_write_en;
  logic [DW-1:0] ram_dout = '0;

  spram_arbiter_2port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CONSECUTIVE(MAXC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_write_en(ram_write_en), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // SPRAM macro: byte-lane writes, registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_write_en[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
    if (ram_write_en[1]) mem[ram_addr][15:8] <= ram_din[15:8];
    ram_dout <= mem[ram_addr];
  end

  int nchecks = 0;
  int nerr    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            wait_cnt;
  logic          last_owner;
  logic [1:0]    e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic          p1_v, vis_v, p1_o, vis_o;
  logic [DW-1:0] p1_d, vis_d;
  logic          lg0, lg1;
  logic          seen_g1, seen_rv0, seen_rv1;
  logic [DW-1:0] seen_rdata;

  task automatic model_reset();
    wait_cnt = 0; last_owner = 1'b1;
    e_we = 2'b00; e_addr = '0; e_din = '0;
    p1_v = 1'b0; vis_v = 1'b0; p1_o = 1'b0; vis_o = 1'b0; p1_d = '0; vis_d = '0;
    lg0 = 1'b0; lg1 = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic g0, g1, owner;
    logic [1:0] we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    @(negedge clk);
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
    g1 = m1_req && (!m0_req || last_owner == 1'b0);
`else
    g1 = m1_req && (!m0_req || wait_cnt == MAXC);
`endif
    g0 = m0_req && !g1;
    chk("m0_gnt", 32'(m0_gnt), 32'(g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g1));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(vis_v && vis_o == 1'b0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(vis_v && vis_o == 1'b1));
    if (vis_v) chk("rdata", 32'(rdata), 32'(vis_d));
    chk("ram_write_en", 32'(ram_write_en), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_din", 32'(ram_din), 32'(e_din));
    seen_g1 = m1_gnt; seen_rv0 = m0_rvalid; seen_rv1 = m1_rvalid; seen_rdata = rdata;
    @(posedge clk);
    vis_v = p1_v; vis_o = p1_o; vis_d = p1_d;
    p1_v = 1'b0;
    if (g0 || g1) begin
      owner = g1;
      we = g1 ? m1_we : m0_we;
      a  = g1 ? m1_addr : m0_addr;
      wd = g1 ? m1_wdata : m0_wdata;
      e_we = we; e_addr = a; e_din = wd;
      if (we == 2'b00) begin
        p1_v = 1'b1; p1_o = owner; p1_d = shadow[a];
      end else begin
        if (we[0]) shadow[a][7:0]  = wd[7:0];
        if (we[1]) shadow[a][15:8] = wd[15:8];
      end
      last_owner = owner;
    end else begin
      e_we = 2'b00;
    end
    if (!m1_req || g1) wait_cnt = 0;
    else if (g0 && wait_cnt < MAXC) wait_cnt++;
    lg0 = g0; lg1 = g1;
    #1;
  endtask

  task automatic set_m0(input logic r, input logic [1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic [1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  // Pulse reset asynchronously mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_ram_write_en", 32'(ram_write_en), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    model_reset();
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  logic [AW-1:0] pool [0:7];

  initial begin
    pool[0] = 14'h0000; pool[1] = 14'h0010; pool[2] = 14'h0020; pool[3] = 14'h0001;
    pool[4] = 14'h1234; pool[5] = 14'h2AAA; pool[6] = 14'h3FFE; pool[7] = 14'h3FFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Give every pool address known contents.
    for (int i = 0; i < 8; i++) begin
      set_m1(1'b1, 2'b11, pool[i], 16'($urandom));
      cycle();
    end
    set_m1(1'b0, 2'b00, '0, '0);

    // Full write then read back on m0.
    set_m0(1'b1, 2'b11, 14'h0010, 16'hBEEF); cycle();
    set_m0(1'b1, 2'b00, 14'h0010, 16'h0000); cycle();
    set_m0(1'b0, 2'b00, 14'h0010, 16'h0000); cycle(); cycle();
    chk("beef_rvalid", 32'(seen_rv0), 32'd1);
    chk("beef_m1_rvalid", 32'(seen_rv1), 32'd0);
    chk("beef_rdata", 32'(seen_rdata), 32'h0000BEEF);

    // Low byte lane only.
    set_m0(1'b1, 2'b11, 14'h0020, 16'hAAAA); cycle();
    set_m0(1'b1, 2'b01, 14'h0020, 16'h5555); cycle();
    set_m0(1'b1, 2'b00, 14'h0020, 16'h0000); cycle();
    set_m0(1'b0, 2'b00, 14'h0020, 16'h0000); cycle(); cycle();
    chk("lane_rdata", 32'(seen_rdata), 32'h0000AA55);

    // Back-to-back reads across the address range ends.
    set_m0(1'b1, 2'b11, 14'h3FFF, 16'h1357); cycle();
    set_m0(1'b0, 2'b00, 14'h0000, 16'h0000);
    set_m1(1'b1, 2'b11, 14'h0000, 16'h2468); cycle();
    set_m1(1'b0, 2'b00, 14'h0000, 16'h0000);
    set_m0(1'b1, 2'b00, 14'h3FFF, 16'h0000); cycle();
    set_m0(1'b0, 2'b00, 14'h0000, 16'h0000);
    set_m1(1'b1, 2'b00, 14'h0000, 16'h0000); cycle();
    set_m1(1'b0, 2'b00, 14'h0000, 16'h0000); cycle();
    chk("b2b_m0_rvalid", 32'(seen_rv0), 32'd1);
    chk("b2b_m0_rdata", 32'(seen_rdata), 32'h00001357);
    cycle();
    chk("b2b_m1_rvalid", 32'(seen_rv1), 32'd1);
    chk("b2b_m1_rdata", 32'(seen_rdata), 32'h00002468);
    chk("b2b_mem_0001", 32'(mem[14'h0001]), 32'(shadow[14'h0001]));

    // Contention pattern from a fresh reset.
    do_reset();
    set_m0(1'b1, 2'b00, 14'h0010, 16'h0000);
    set_m1(1'b1, 2'b00, 14'h0020, 16'h0000);
    for (int i = 0; i < 15; i++) begin
      cycle();
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
      chk("rr_pattern", 32'(seen_g1), 32'(i % 2));
`else
      chk("prio_pattern", 32'(seen_g1), 32'(i % (MAXC + 1) == MAXC));
`endif
    end

    // Reset while a read sits in stage 1.
    set_m1(1'b0, 2'b00, 14'h0000, 16'h0000);
    cycle();
    do_reset();
    set_m0(1'b0, 2'b00, 14'h0000, 16'h0000);
    cycle(); cycle();
    chk("post_rst_rvalid", 32'(seen_rv0 | seen_rv1), 32'd0);
    cycle();

    // Random traffic with hold-until-grant and occasional request drops.
    for (int n = 0; n < 400; n++) begin
      if (!(m0_req && !lg0 && $urandom_range(0, 3) != 0)) begin
        m0_req   = ($urandom_range(0, 2) != 0);
        m0_we    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        m0_addr  = pool[$urandom_range(0, 7)];
        m0_wdata = 16'($urandom);
      end
      if (!(m1_req && !lg1 && $urandom_range(0, 3) != 0)) begin
        m1_req   = ($urandom_range(0, 2) != 0);
        m1_we    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        m1_addr  = pool[$urandom_range(0, 7)];
        m1_wdata = 16'($urandom);
      end
      cycle();
    end
    set_m0(1'b0, 2'b00, '0, '0);
    set_m1(1'b0, 2'b00, '0, '0);
    cycle(); cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
